// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and picks the next fetch address.
// Each cycle the next PC is one of: sequential (+STEP), branch target, jump
// target, or the current PC held. A redirect costs one fetch bubble and a
// one-cycle flush pulse to decode. The FSM is split into a register process,
// a next-state process and an output process.
module pc_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = 8'h00,
  parameter int                STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              flush,
  output logic [7:0]        bubble_cnt
);

  // STEP is a power of two, so the word offset becomes a shift and the
  // alignment is a mask over the low log2(STEP) bits.
  localparam int                SHIFT      = $clog2(STEP);
  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic [7:0]        bubbleCnt_q, bubbleCnt_d;

  logic [ADDR_W-1:0] pcPlusStep;
  logic [ADDR_W-1:0] brDelta;
  logic [ADDR_W-1:0] brTarget;
  logic [ADDR_W-1:0] jmpTarget;

  // Candidate addresses; all arithmetic wraps modulo 2^ADDR_W. The offset is
  // sign-extended before scaling, which is the same as a plain left shift
  // once the result is truncated back to ADDR_W bits.
  always_comb begin
    pcPlusStep = pc_q + STEP_V;
    brDelta    = br_offset << SHIFT;
    brTarget   = (pcPlusStep + brDelta) & ALIGN_MASK;
    jmpTarget  = jmp_target & ALIGN_MASK;
  end

  // State, PC, flush and bubble counter registers; reset aborts everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC & ALIGN_MASK;
      flush_q     <= 1'b0;
      bubbleCnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  // Next-state and next-PC selection: halt, then jump, then branch, then
  // stall, then sequential. Flush is raised only by an accepted redirect.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = 1'b0;
    bubbleCnt_d = bubbleCnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (jmp) begin
          pc_d    = jmpTarget;
          flush_d = 1'b1;
          state_d = BUBBLE;
        end else if (br_taken) begin
          pc_d    = brTarget;
          flush_d = 1'b1;
          state_d = BUBBLE;
        end else if (!stall) begin
          pc_d = pcPlusStep & ALIGN_MASK;
        end
      end
      BUBBLE: begin
        if (bubbleCnt_q != 8'hFF) begin
          bubbleCnt_d = bubbleCnt_q + 8'd1;
        end
        state_d = halt ? HALTED : RUN;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come from registers only; fetch_valid is a pure state decode.
  always_comb begin
    pc_out      = pc_q;
    pc_plus4    = pcPlusStep;
    fetch_valid = (state_q == RUN);
    flush       = flush_q;
    bubble_cnt  = bubbleCnt_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed steps followed by random traffic, checked every
// cycle against a behavioural model of the fetch controller.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
  logic       halt;
  logic       br_taken;
  logic [7:0] br_offset;
  logic       jmp;
  logic [7:0] jmp_target;
  logic [7:0] pc_out;
  logic [7:0] pc_plus4;
  logic       fetch_valid;
  logic       flush;
  logic [7:0] bubble_cnt;

  int checks;
  int errors;

  // Behavioural model: where the PC is, whether fetching has begun, whether
  // it is stopped for good, and whether the cycle after a redirect is dead.
  int mPc;
  int mCnt;
  bit mStarted;
  bit mHalted;
  bit mBubble;
  bit mFlush;

  pc_sequencer #(
    .ADDR_W   (8),
    .RESET_VEC(8'h00),
    .STEP     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .halt       (halt),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .fetch_valid(fetch_valid),
    .flush      (flush),
    .bubble_cnt (bubble_cnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc      = 0;
    mCnt     = 0;
    mStarted = 1'b0;
    mHalted  = 1'b0;
    mBubble  = 1'b0;
    mFlush   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    int t;
    int off;
    int jt;
    if (mHalted) begin
      mFlush = 1'b0;
    end else if (!mStarted) begin
      if (start) mStarted = 1'b1;
    end else if (mBubble) begin
      mBubble = 1'b0;
      mFlush  = 1'b0;
      if (mCnt < 255) mCnt++;
      if (halt) mHalted = 1'b1;
    end else begin
      mFlush = 1'b0;
      if (halt) begin
        mHalted = 1'b1;
      end else if (jmp) begin
        jt      = int'(jmp_target);
        mPc     = jt - (jt % 4);
        mFlush  = 1'b1;
        mBubble = 1'b1;
      end else if (br_taken) begin
        off     = int'($signed(br_offset));
        t       = mPc + 4 + off * 4;
        mPc     = ((t % 256) + 256) % 256;
        mFlush  = 1'b1;
        mBubble = 1'b1;
      end else if (!stall) begin
        mPc = (mPc + 4) % 256;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp8({tag, ".pc_out"},      pc_out,      8'(mPc));
    cmp8({tag, ".pc_plus4"},    pc_plus4,    8'((mPc + 4) % 256));
    cmp1({tag, ".fetch_valid"}, fetch_valid, mStarted && !mHalted && !mBubble);
    cmp1({tag, ".flush"},       flush,       mFlush);
    cmp8({tag, ".bubble_cnt"},  bubble_cnt,  8'(mCnt));
  endtask

  task automatic clearInputs();
    start      = 1'b0;
    stall      = 1'b0;
    halt       = 1'b0;
    br_taken   = 1'b0;
    br_offset  = 8'h00;
    jmp        = 1'b0;
    jmp_target = 8'h00;
  endtask

  // One clock: model first, then the edge, then sample 1 time unit later.
  task automatic applyStimulus(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic randomInputs();
    start      = 1'($urandom_range(0, 1));
    stall      = ($urandom_range(0, 3) == 0);
    halt       = ($urandom_range(0, 63) == 0);
    br_taken   = ($urandom_range(0, 5) == 0);
    jmp        = ($urandom_range(0, 7) == 0);
    br_offset  = 8'($urandom);
    jmp_target = 8'($urandom);
  endtask

  task automatic doReset();
    clearInputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clearInputs();
    modelReset();

    // Reset values.
    doReset();
    cmp1("reset.valid_const", fetch_valid, 1'b0);

    // Start, then sequential fetch 0x00, 0x04, 0x08, 0x0C.
    start = 1'b1;
    applyStimulus("start");
    cmp8("seq0", pc_out, 8'h00);
    start = 1'b0;
    applyStimulus("seq");
    cmp8("seq1", pc_out, 8'h04);
    applyStimulus("seq");
    cmp8("seq2", pc_out, 8'h08);
    applyStimulus("seq");
    cmp8("seq3", pc_out, 8'h0C);
    applyStimulus("seq");
    cmp8("seq4", pc_out, 8'h10);

    // Backward branch -2 words from 0x10 lands on 0x0C.
    br_taken  = 1'b1;
    br_offset = 8'hFE;
    applyStimulus("br");
    cmp8("br.target", pc_out, 8'h0C);
    cmp1("br.flush", flush, 1'b1);
    cmp1("br.bubble", fetch_valid, 1'b0);
    clearInputs();
    applyStimulus("br_after");
    cmp1("br.flush_drop", flush, 1'b0);
    cmp8("br.cnt", bubble_cnt, 8'd1);
    applyStimulus("br_after");
    cmp8("br.next", pc_out, 8'h10);

    // Walk to 0x20, then jump and branch together: jump wins and is aligned.
    for (int i = 0; i < 4; i++) applyStimulus("walk20");
    cmp8("walk20", pc_out, 8'h20);
    jmp        = 1'b1;
    jmp_target = 8'h47;
    br_taken   = 1'b1;
    br_offset  = 8'h05;
    applyStimulus("jmp_br");
    cmp8("jmp.target", pc_out, 8'h44);
    clearInputs();
    applyStimulus("jmp_after");
    cmp1("jmp.flush_once", flush, 1'b0);

    // Jump to 0x30, stall three cycles, then move on.
    jmp        = 1'b1;
    jmp_target = 8'h30;
    applyStimulus("jmp30");
    clearInputs();
    applyStimulus("jmp30_after");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall");
      cmp8("stall.pc", pc_out, 8'h30);
      cmp1("stall.valid", fetch_valid, 1'b1);
    end
    stall = 1'b0;
    applyStimulus("unstall");
    cmp8("unstall.pc", pc_out, 8'h34);
    stall     = 1'b1;
    br_taken  = 1'b1;
    br_offset = 8'h02;
    applyStimulus("stall_br");
    cmp8("stall_br.pc", pc_out, 8'h40);
    clearInputs();
    applyStimulus("stall_br_after");

    // Wrap at the top of the address space, then halt.
    jmp        = 1'b1;
    jmp_target = 8'hF0;
    applyStimulus("jmpF0");
    clearInputs();
    applyStimulus("jmpF0_after");
    for (int i = 0; i < 3; i++) applyStimulus("toFC");
    cmp8("toFC", pc_out, 8'hFC);
    applyStimulus("wrap");
    cmp8("wrap.pc", pc_out, 8'h00);
    halt = 1'b1;
    applyStimulus("halt");
    for (int i = 0; i < 10; i++) begin
      randomInputs();
      applyStimulus("halted");
      cmp8("halted.pc", pc_out, 8'h00);
      cmp1("halted.valid", fetch_valid, 1'b0);
    end

    // Asynchronous reset during a bubble cycle.
    doReset();
    start = 1'b1;
    applyStimulus("start2");
    start      = 1'b0;
    jmp        = 1'b1;
    jmp_target = 8'h80;
    applyStimulus("pre_async");
    clearInputs();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    cmp8("async.pc", pc_out, 8'h00);
    cmp1("async.valid", fetch_valid, 1'b0);
    cmp1("async.flush", flush, 1'b0);
    cmp8("async.cnt", bubble_cnt, 8'd0);
    #2;
    rst = 1'b0;

    // 300 back-to-back jumps saturate the bubble counter.
    start = 1'b1;
    applyStimulus("start3");
    start = 1'b0;
    jmp   = 1'b1;
    for (int i = 0; i < 600; i++) begin
      jmp_target = 8'($urandom);
      applyStimulus("sat");
    end
    cmp8("sat.cnt", bubble_cnt, 8'd255);
    clearInputs();

    // Random episodes, each from a fresh reset.
    for (int ep = 0; ep < 4; ep++) begin
      doReset();
      for (int i = 0; i < 400; i++) begin
        randomInputs();
        applyStimulus("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
